// File: rtl/life_engine.sv
// life_engine: Game-of-Life engine that advances one generation per step pulse or per programmed period.
// Defining LIFE_STILL_DETECT_EN adds a still-life comparator that halts the engine with stable=1.
module life_engine #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int WRAP = 1,
  parameter int GEN_W = 16,
  parameter int PERIOD_W = 24,
  parameter logic [ROWS*COLS-1:0] INIT = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] load_pattern,
  input  logic                 step,
  input  logic                 run,
  input  logic [PERIOD_W-1:0]  period,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     generation,
  output logic                 gen_tick,
  output logic                 running,
  output logic                 extinct,
  output logic                 stable
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t                state;
  logic [PERIOD_W-1:0]   timer;
  logic [PERIOD_W-1:0]   period_eff;
  logic                  terminal;
  logic                  advance;
  logic                  next_zero;
  logic                  still;
  logic [ROWS*COLS-1:0]  next_grid;

  // Each cell sums its eight neighbours; off-grid neighbours read as dead unless WRAP folds them around.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nb;
      logic [3:0] n;
      for (genvar k = 0; k < 9; k++) begin : g_k
        if (k != 4) begin : g_nb
          localparam int DR = k / 3 - 1;
          localparam int DC = k % 3 - 1;
          localparam int RR = (r + DR + ROWS) % ROWS;
          localparam int CC = (c + DC + COLS) % COLS;
          localparam int IDX = RR * COLS + CC;
          localparam int NI = (k < 4) ? k : k - 1;
          localparam bit ON_GRID = (r + DR >= 0) && (r + DR < ROWS) &&
                                   (c + DC >= 0) && (c + DC < COLS);
          assign nb[NI] = (WRAP != 0 || ON_GRID) ? grid[IDX] : 1'b0;
        end
      end
      assign n = {3'b000, nb[0]} + {3'b000, nb[1]} + {3'b000, nb[2]} + {3'b000, nb[3]} +
                 {3'b000, nb[4]} + {3'b000, nb[5]} + {3'b000, nb[6]} + {3'b000, nb[7]};
      assign next_grid[r*COLS+c] = (n == 4'd3) || (grid[r*COLS+c] && (n == 4'd2));
    end
  end

  assign period_eff = (period == '0) ? {{(PERIOD_W-1){1'b0}}, 1'b1} : period;
  // Compared every cycle, so a shortened period that the timer already passed fires at once.
  assign terminal   = ({1'b0, timer} + {{PERIOD_W{1'b0}}, 1'b1}) >= {1'b0, period_eff};
  assign advance    = !load && (((state == S_IDLE) && step) ||
                                ((state == S_RUN) && run && terminal));
  assign next_zero  = (next_grid == '0);
  assign running    = (state == S_RUN);

`ifdef LIFE_STILL_DETECT_EN
  assign still = (next_grid == grid);
`else
  assign still  = 1'b0;
  assign stable = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grid       <= INIT;
      generation <= '0;
      timer      <= '0;
      state      <= S_IDLE;
      gen_tick   <= 1'b0;
      extinct    <= 1'b0;
`ifdef LIFE_STILL_DETECT_EN
      stable     <= 1'b0;
`endif
    end else begin
      gen_tick <= 1'b0;
      if (load) begin
        grid       <= load_pattern;
        generation <= '0;
        timer      <= '0;
        state      <= S_IDLE;
        extinct    <= 1'b0;
`ifdef LIFE_STILL_DETECT_EN
        stable     <= 1'b0;
`endif
      end else if (advance) begin
        grid       <= next_grid;
        generation <= generation + {{(GEN_W-1){1'b0}}, 1'b1};
        gen_tick   <= 1'b1;
        timer      <= '0;
        if (next_zero) begin
          state   <= S_HALT;
          extinct <= 1'b1;
        end else if (still) begin
          state  <= S_HALT;
`ifdef LIFE_STILL_DETECT_EN
          stable <= 1'b1;
`endif
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (run) begin
              state <= S_RUN;
              timer <= '0;
            end
          end
          S_RUN: begin
            if (!run) begin
              state <= S_IDLE;
              timer <= '0;
            end else begin
              timer <= timer + {{(PERIOD_W-1){1'b0}}, 1'b1};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
